aes_round_sequencer: RTL and testbench

//  Parametrised AES cipher round controller; generalises the fixed AES-128 StateMachine to runtime key length (Nr=10/12/14).

---
 rtl/aes_round_sequencer.sv | 181 ++++++++++++++++++
 tb/tb_aes_round_sequencer.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/aes_round_sequencer.sv
// aes_round_sequencer: AES cipher round controller, Nr = 10/12/14 chosen at runtime.
// Optional per-stage ready watchdog: define AES_SEQ_WDT_EN.
module aes_round_sequencer #(
  parameter int DATA_W     = 128,
  parameter int KSEL_W     = 4,
  parameter int WDT_CYCLES = 255
) (
  input  logic                Clk,
  input  logic                Rst_n,
  input  logic                Start,
  input  logic [1:0]          KeyLen,
  input  logic [DATA_W-1:0]   PT,
  output logic [DATA_W-1:0]   CT,
  output logic                Busy,
  output logic                Ry,
  output logic                Err,
  output logic [3:0]          Stg_En,
  output logic [3:0]          Stg_Clr,
  input  logic [3:0]          Stg_Ry,
  output logic [DATA_W-1:0]   Text,
  input  logic [4*DATA_W-1:0] Stg_Text,
  output logic [KSEL_W-1:0]   KeySel
);

  typedef enum logic [2:0] {
    IDLE, ISSUE, WAIT, DONE, ERR
  } state_t;

  localparam logic [3:0] ARK = 4'b0001;
  localparam logic [3:0] SBT = 4'b0010;
  localparam logic [3:0] SHR = 4'b0100;
  localparam logic [3:0] MXC = 4'b1000;

  state_t            state;
  logic [DATA_W-1:0] work;
  logic [3:0]        cur;
  logic [3:0]        rnd;
  logic [3:0]        nr;
  logic              bad_kl;

  logic              hit;
  logic              last;
  logic [DATA_W-1:0] slice;
  logic [3:0]        nxt_cur;
  logic [3:0]        nxt_rnd;

`ifdef AES_SEQ_WDT_EN
  localparam int WDT_W =
    (WDT_CYCLES > 255) ? $clog2(WDT_CYCLES + 1) : 8;
  logic [WDT_W-1:0] cnt;
  logic             wdt_hit;
  assign wdt_hit = (cnt == WDT_W'(WDT_CYCLES - 1));
`else
  logic unused_wdt;
  assign unused_wdt = (WDT_CYCLES > 0);
`endif

  // Result mux, ready match and next-stage selection
  always_comb begin
    hit     = |(Stg_Ry & cur);
    last    = cur[0] && (rnd == nr);
    slice   = Stg_Text[DATA_W-1:0];
    nxt_cur = ARK;
    nxt_rnd = rnd;
    unique case (1'b1)
      cur[0]: begin
        slice   = Stg_Text[0 +: DATA_W];
        nxt_cur = SBT;
        nxt_rnd = rnd + 4'd1;
      end
      cur[1]: begin
        slice   = Stg_Text[DATA_W +: DATA_W];
        nxt_cur = SHR;
      end
      cur[2]: begin
        slice   = Stg_Text[2*DATA_W +: DATA_W];
        nxt_cur = (rnd == nr) ? ARK : MXC;
      end
      cur[3]: begin
        slice   = Stg_Text[3*DATA_W +: DATA_W];
        nxt_cur = ARK;
      end
      default: ;
    endcase
  end

`ifdef AES_SEQ_WDT_EN
  // Cycles elapsed since the current stage was issued
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      cnt <= '0;
    end else if (state == ISSUE) begin
      cnt <= WDT_W'(1);
    end else if (state == WAIT) begin
      cnt <= cnt + WDT_W'(1);
    end else begin
      cnt <= '0;
    end
  end
`endif

  // Round sequencing FSM with registered outputs
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state   <= IDLE;
      work    <= '0;
      cur     <= '0;
      rnd     <= '0;
      nr      <= '0;
      bad_kl  <= 1'b0;
      CT      <= '0;
      Busy    <= 1'b0;
      Ry      <= 1'b0;
      Err     <= 1'b0;
      Stg_En  <= '0;
      Stg_Clr <= '0;
      Text    <= '0;
      KeySel  <= '0;
    end else begin
      Stg_En  <= '0;
      Stg_Clr <= '0;
      Ry      <= 1'b0;
      Err     <= bad_kl;
      bad_kl  <= 1'b0;
      unique case (state)
        IDLE: begin
          if (Busy) begin
            state  <= ISSUE;
            cur    <= ARK;
            rnd    <= '0;
            Stg_En <= ARK;
            Text   <= work;
            KeySel <= '0;
          end else if (Start) begin
            if (KeyLen == 2'd3) begin
              bad_kl <= 1'b1;
            end else begin
              work    <= PT;
              nr      <= 4'd10 + {1'b0, KeyLen, 1'b0};
              Stg_Clr <= 4'hF;
              Busy    <= 1'b1;
            end
          end
        end
        ISSUE: state <= WAIT;
        WAIT: begin
          if (hit) begin
            work <= slice;
            if (last) begin
              state <= DONE;
              CT    <= slice;
              Ry    <= 1'b1;
            end else begin
              state  <= ISSUE;
              cur    <= nxt_cur;
              rnd    <= nxt_rnd;
              Stg_En <= nxt_cur;
              Text   <= slice;
              if (nxt_cur[0]) KeySel <= KSEL_W'(nxt_rnd);
            end
          end
`ifdef AES_SEQ_WDT_EN
          else if (wdt_hit) begin
            state   <= ERR;
            Err     <= 1'b1;
            Stg_Clr <= 4'hF;
            Busy    <= 1'b0;
          end
`endif
        end
        DONE: begin
          state <= IDLE;
          Busy  <= 1'b0;
        end
        ERR: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_aes_round_sequencer.sv
// tb_aes_round_sequencer: directed bench for the AES round sequencer.
// Stage units are modelled by latency stubs driven from Stg_En.
module tb_aes_round_sequencer;

  logic         Clk = 1'b0;
  logic         Rst_n = 1'b0;
  logic         Start = 1'b0;
  logic [1:0]   KeyLen = 2'd0;
  logic [127:0] PT = '0;
  logic [127:0] CT;
  logic         Busy, Ry, Err;
  logic [3:0]   Stg_En, Stg_Clr;
  logic [3:0]   Stg_Ry = 4'h0;
  logic [127:0] Text;
  logic [511:0] Stg_Text;
  logic [3:0]   KeySel;

  aes_round_sequencer dut (
    .Clk(Clk), .Rst_n(Rst_n), .Start(Start), .KeyLen(KeyLen),
    .PT(PT), .CT(CT), .Busy(Busy), .Ry(Ry), .Err(Err),
    .Stg_En(Stg_En), .Stg_Clr(Stg_Clr), .Stg_Ry(Stg_Ry),
    .Text(Text), .Stg_Text(Stg_Text), .KeySel(KeySel)
  );

  always #5 Clk = ~Clk;

  localparam logic [127:0] PT0 = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] SHR_K = {16{8'h0f}};

  int n_tests = 0;
  int n_fail  = 0;

  int       lat = 1;
  bit       force_ry = 1'b0;
  bit       xform = 1'b0;
  logic [3:0] hold = 4'h0;

  function automatic logic [127:0] f_ark(input logic [127:0] x, input logic [3:0] k);
    return x ^ {32{k}};
  endfunction
  function automatic logic [127:0] f_sbt(input logic [127:0] x);
    return {x[126:0], x[127]};
  endfunction
  function automatic logic [127:0] f_shr(input logic [127:0] x);
    return x ^ SHR_K;
  endfunction
  function automatic logic [127:0] f_mxc(input logic [127:0] x);
    return x + 128'd1;
  endfunction

  function automatic logic [127:0] model(input logic [127:0] p, input int nr);
    logic [127:0] x;
    x = f_ark(p, 4'd0);
    for (int r = 1; r < nr; r++)
      x = f_ark(f_mxc(f_shr(f_sbt(x))), 4'(r));
    return f_ark(f_shr(f_sbt(x)), 4'(nr));
  endfunction

  assign Stg_Text = xform ?
    {f_mxc(Text), f_shr(Text), f_sbt(Text), f_ark(Text, KeySel)} :
    {4{Text}};

  int         dly [4];
  logic [3:0] ry_s, pend;

  always @(posedge Clk) begin
    #1;
    for (int i = 0; i < 4; i++) begin
      ry_s[i] = 1'b0;
      if (!Rst_n) dly[i] = 0;
      else if (Stg_En[i]) dly[i] = lat;
      else if (dly[i] != 0) begin
        dly[i]--;
        if (dly[i] == 0 && !hold[i]) ry_s[i] = 1'b1;
      end
      pend[i] = (dly[i] != 0);
    end
    Stg_Ry = ry_s | (force_ry ? ~pend : 4'h0);
  end

  int           en_n [4];
  logic [3:0]   ks_q [$];
  int           first_en, shr_cyc, clr0, clr_last;
  int           ry_cyc, ry_n, err_cyc, err_n, busy_n;
  logic [127:0] ct_ry;

  task automatic chk(input string tag, input logic [127:0] got,
                     input logic [127:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic sample(input int k);
    for (int i = 0; i < 4; i++) if (Stg_En[i]) en_n[i]++;
    if (Stg_En != 0 && first_en < 0) first_en = k;
    if (Stg_En[0]) ks_q.push_back(KeySel);
    if (Stg_En[2] && shr_cyc < 0) shr_cyc = k;
    if (Stg_Clr == 4'hF) begin
      if (clr0 < 0) clr0 = k;
      clr_last = k;
    end
    if (Ry) begin
      ry_n++;
      if (ry_cyc < 0) begin ry_cyc = k; ct_ry = CT; end
    end
    if (Err) begin
      err_n++;
      if (err_cyc < 0) err_cyc = k;
    end
    if (Busy) busy_n++;
  endtask

  task automatic run(input logic [1:0] kl, input logic [127:0] p,
                     input int l, input bit extra, input bit frc,
                     input logic [3:0] hld, input int rst_at,
                     input int limit);
    int fin;
    lat = l; force_ry = frc; hold = hld;
    for (int i = 0; i < 4; i++) en_n[i] = 0;
    ks_q.delete();
    first_en = -1; shr_cyc = -1; clr0 = -1; clr_last = -1;
    ry_cyc = -1; ry_n = 0; err_cyc = -1; err_n = 0; busy_n = 0;
    ct_ry = '0;
    @(negedge Clk);
    Start = 1'b1; KeyLen = kl; PT = p;
    for (int k = 0; k <= limit; k++) begin
      @(negedge Clk);
      sample(k);
      if (extra && k < 78 && (k % 5) == 2) begin
        Start = 1'b1; KeyLen = (k % 2) ? 2'd3 : 2'd2; PT = ~p;
      end else begin
        Start = 1'b0; KeyLen = kl; PT = p;
      end
      if (k == rst_at) begin
        Rst_n = 1'b0;
        #1;
        chk("rst_ct", CT, '0);
        chk("rst_text", Text, '0);
        chk("rst_ctl", {KeySel, Stg_En, Stg_Clr, Busy, Ry, Err}, '0);
        @(negedge Clk);
        @(negedge Clk);
        Rst_n = 1'b1;
        break;
      end
      fin = (ry_cyc >= 0) ? ry_cyc : err_cyc;
      if (fin >= 0 && k >= fin + 3) break;
    end
    Start = 1'b0;
  endtask

  task automatic chk_t1(input string t);
    chk({t, "_ct"}, ct_ry, PT0);
    chk({t, "_ry"}, ry_cyc, 81);
    chk({t, "_ry_n"}, ry_n, 1);
    chk({t, "_en1"}, first_en, 1);
    chk({t, "_clr"}, clr0, 0);
    chk({t, "_busy"}, busy_n, 82);
    chk({t, "_ark"}, en_n[0], 11);
    chk({t, "_sbt"}, en_n[1], 10);
    chk({t, "_shr"}, en_n[2], 10);
    chk({t, "_mxc"}, en_n[3], 9);
    chk({t, "_ksn"}, ks_q.size(), 11);
    foreach (ks_q[i]) chk({t, "_ks"}, ks_q[i], i);
  endtask

  initial begin
    repeat (3) @(negedge Clk);
    chk("reset_ct", CT, '0);
    chk("reset_ctl", {KeySel, Stg_En, Stg_Clr, Busy, Ry, Err}, '0);
    Rst_n = 1'b1;
    @(negedge Clk);
    chk("idle_ctl", {KeySel, Stg_En, Stg_Clr, Busy, Ry, Err}, '0);

    run(2'd0, PT0, 1, 1'b0, 1'b0, 4'h0, -1, 100);
    chk_t1("t1");

    run(2'd2, PT0, 3, 1'b0, 1'b0, 4'h0, -1, 260);
    chk("t2_ct", ct_ry, PT0);
    chk("t2_ry", ry_cyc, 225);
    chk("t2_ark", en_n[0], 15);
    chk("t2_shr", en_n[2], 14);
    chk("t2_mxc", en_n[3], 13);
    chk("t2_kslast", ks_q[$], 14);

    run(2'd3, PT0, 1, 1'b0, 1'b0, 4'h0, -1, 20);
    chk("t3_err", err_cyc, 1);
    chk("t3_err_n", err_n, 1);
    chk("t3_busy", busy_n, 0);
    chk("t3_en", en_n[0] + en_n[1] + en_n[2] + en_n[3], 0);
    chk("t3_ry", ry_n, 0);

    run(2'd0, PT0, 1, 1'b1, 1'b1, 4'h0, -1, 100);
    chk_t1("t4");
    chk("t4_err", err_n, 0);

    run(2'd0, PT0, 1, 1'b0, 1'b0, 4'h0, 30, 100);
    chk("t5_ry", ry_n, 0);
    run(2'd0, PT0, 1, 1'b0, 1'b0, 4'h0, -1, 100);
    chk_t1("t5");

    xform = 1'b1;
    run(2'd1, PT0, 2, 1'b0, 1'b0, 4'h0, -1, 170);
    chk("t6_ct", ct_ry, model(PT0, 12));
    chk("t6_ry", ry_cyc, 145);
    chk("t6_ksn", ks_q.size(), 13);
    xform = 1'b0;

    run(2'd0, PT0, 1, 1'b0, 1'b0, 4'b0100, -1, 300);
    chk("t7_shr", shr_cyc, 5);
    chk("t7_ry", ry_n, 0);
`ifdef AES_SEQ_WDT_EN
    chk("t7_err", err_cyc, 260);
    chk("t7_err_n", err_n, 1);
    chk("t7_clr", clr_last, 260);
    chk("t7_busy", Busy, 1'b0);
`else
    chk("t7_err_n", err_n, 0);
    chk("t7_busy", Busy, 1'b1);
`endif
    hold = 4'h0;
    Rst_n = 1'b0;
    @(negedge Clk);
    @(negedge Clk);
    Rst_n = 1'b1;
    run(2'd0, PT0, 1, 1'b0, 1'b0, 4'h0, -1, 100);
    chk_t1("t8");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
